// File: rtl/norm_pkg.sv
// Shared constants and payload types for the 12-bit mantissa normalization stage.
package norm_pkg;

    localparam int unsigned MANT_W     = 12;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned NORM_EXP_W = 8;

    // S1 -> S2 payload: coarse-shifted sum plus what S2 needs to finish the job
    typedef struct packed {
        logic [MANT_W-1:0]     sh1;
        logic [IDX_W-1:0]      c_pre;
        logic                  v_pre;
        logic [NORM_EXP_W-1:0] exp;
    } norm_stage_t;

    typedef struct packed {
        logic [MANT_W-1:0]     mant;
        logic [IDX_W-1:0]      shamt;
        logic [NORM_EXP_W-1:0] exp;
        logic                  corr;
        logic                  zero;
        logic                  unf;
    } norm_out_t;

endpackage

// File: rtl/norm_shl12.sv
// Combinational 12-bit logarithmic left shifter; amounts of 12..15 yield zero.
module norm_shl12
    import norm_pkg::*;
(
    input  logic [MANT_W-1:0] i_data,
    input  logic [IDX_W-1:0]  i_amt,
    output logic [MANT_W-1:0] o_data
);

    logic [MANT_W-1:0] w_st1;
    logic [MANT_W-1:0] w_st2;
    logic [MANT_W-1:0] w_st4;

    always_comb begin
        w_st1  = i_amt[0] ? {i_data[MANT_W-2:0], 1'b0} : i_data;
        w_st2  = i_amt[1] ? {w_st1[MANT_W-3:0], 2'b0}  : w_st1;
        w_st4  = i_amt[2] ? {w_st2[MANT_W-5:0], 4'b0}  : w_st2;
        o_data = i_amt[3] ? {w_st4[MANT_W-9:0], 8'b0}  : w_st4;
    end

endmodule

// File: rtl/norm_shift_12.sv
// Two-stage normalize/exponent-adjust pipeline with valid/ready handshake.
// Optional prediction checker enabled by defining NORM_PRED_CHECK_EN.
module norm_shift_12
    import norm_pkg::*;
#(
    // Payload structs are sized by NORM_EXP_W; keep the two in step
    parameter int unsigned EXP_W = NORM_EXP_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [MANT_W-1:0] i_sum,
    input  logic [IDX_W-1:0]  i_c_pre,
    input  logic              i_v_pre,
    input  logic [EXP_W-1:0]  i_exp_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [MANT_W-1:0] o_mant,
    output logic [IDX_W-1:0]  o_shamt,
    output logic [EXP_W-1:0]  o_exp_out,
    output logic              o_corr,
    output logic              o_zero,
    output logic              o_unf,
    output logic              o_pred_err
);

    logic                  r_s1_valid;
    logic                  r_s2_valid;
    norm_stage_t           r_s1;
    norm_out_t             r_out;

    logic                  w_s1_ready;
    logic                  w_s2_ready;
    logic                  w_s1_load;
    logic                  w_s2_load;
    logic [IDX_W-1:0]      w_sh1_amt;
    logic [MANT_W-1:0]     w_sh1;
    norm_stage_t           w_s1_d;
    norm_out_t             w_out_d;
    logic                  w_corr;
    logic [NORM_EXP_W:0]   w_diff;

    // A stage may load when empty or when its contents leave this same cycle
    assign w_s2_ready = !r_s2_valid || i_out_ready;
    assign w_s1_ready = !r_s1_valid || w_s2_ready;
    assign w_s1_load  = i_in_valid && w_s1_ready;
    assign w_s2_load  = r_s1_valid && w_s2_ready;
    assign o_in_ready = w_s1_ready;

    assign w_sh1_amt = IDX_W'(MANT_W - 1) - i_c_pre;

    norm_shl12 u_shl (
        .i_data (i_sum),
        .i_amt  (w_sh1_amt),
        .o_data (w_sh1)
    );

    always_comb begin
        w_s1_d       = '0;
        w_s1_d.sh1   = w_sh1;
        w_s1_d.c_pre = i_c_pre;
        w_s1_d.v_pre = i_v_pre;
        w_s1_d.exp   = NORM_EXP_W'(i_exp_in);
    end

    // S2: fix the one-position overestimate, then subtract the shift from the exponent
    always_comb begin
        w_out_d = '0;
        w_diff  = '0;
        w_corr  = r_s1.v_pre && !r_s1.sh1[MANT_W-1];
        if (r_s1.v_pre) begin
            if (w_corr) begin
                w_out_d.mant  = {r_s1.sh1[MANT_W-2:0], 1'b0};
                w_out_d.shamt = IDX_W'(MANT_W) - r_s1.c_pre;
                w_out_d.corr  = 1'b1;
            end else begin
                w_out_d.mant  = r_s1.sh1;
                w_out_d.shamt = IDX_W'(MANT_W - 1) - r_s1.c_pre;
            end
            w_diff = {1'b0, r_s1.exp} - {{(NORM_EXP_W + 1 - IDX_W){1'b0}}, w_out_d.shamt};
            if (w_diff[NORM_EXP_W]) begin
                w_out_d.unf = 1'b1;
            end else begin
                w_out_d.exp = w_diff[NORM_EXP_W-1:0];
            end
        end else begin
            w_out_d.zero = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1       <= '0;
            r_out      <= '0;
        end else begin
            if (w_s1_ready) r_s1_valid <= i_in_valid;
            if (w_s1_load)  r_s1       <= w_s1_d;
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (w_s2_load)  r_out      <= w_out_d;
        end
    end

    assign o_out_valid = r_s2_valid;
    assign o_mant      = r_out.mant;
    assign o_shamt     = r_out.shamt;
    assign o_exp_out   = EXP_W'(r_out.exp);
    assign o_corr      = r_out.corr;
    assign o_zero      = r_out.zero;
    assign o_unf       = r_out.unf;

`ifdef NORM_PRED_CHECK_EN
    logic r_pred_err;
    logic w_pred_bad;

    assign w_pred_bad = r_s1.v_pre &&
                        (!w_out_d.mant[MANT_W-1] || (r_s1.c_pre > IDX_W'(MANT_W - 1)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pred_err <= 1'b0;
        end else if (w_s2_load && w_pred_bad) begin
            r_pred_err <= 1'b1;
            $error("norm_shift_12: leading-one prediction out of contract (c_pre=%0d)",
                   r_s1.c_pre);
        end
    end

    assign o_pred_err = r_pred_err;
`else
    assign o_pred_err = 1'b0;
`endif

endmodule

// File: tb/tb_norm_shift_12.sv
// Self-checking bench for norm_shift_12: directed table, streaming model, reset and checker cases.
module tb_norm_shift_12;

    typedef logic [27:0] obs_t;  // {mant, shamt, exp_out, corr, zero, unf, pred_err}

    typedef struct {
        logic [11:0] sum;
        logic [3:0]  c_pre;
        logic        v_pre;
        logic [7:0]  exp_in;
        logic [11:0] mant;
        logic [3:0]  shamt;
        logic [7:0]  exp_out;
        logic        corr;
        logic        zero;
        logic        unf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] sum;
    logic [3:0]  c_pre;
    logic        v_pre;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] mant;
    logic [3:0]  shamt;
    logic [7:0]  exp_out;
    logic        corr;
    logic        zero;
    logic        unf;
    logic        pred_err;
    obs_t        obs;

    int   n_checks = 0;
    int   n_pass   = 0;
    obs_t q[$];
    logic s_in_ready;
    logic s_out_valid;
    vec_t vecs[10];

    norm_shift_12 dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_sum       (sum),
        .i_c_pre     (c_pre),
        .i_v_pre     (v_pre),
        .i_exp_in    (exp_in),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_mant      (mant),
        .o_shamt     (shamt),
        .o_exp_out   (exp_out),
        .o_corr      (corr),
        .o_zero      (zero),
        .o_unf       (unf),
        .o_pred_err  (pred_err)
    );

    assign obs = {mant, shamt, exp_out, corr, zero, unf, pred_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Reference: find the true leading one and normalize directly from it
    function automatic obs_t model(input logic [11:0] s, input logic [3:0] c, input logic v,
                                   input logic [7:0] e);
        int          p;
        int          sh;
        logic [11:0] m;
        logic [7:0]  eo;
        logic        u;
        if (!v) return {12'd0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        p = 0;
        for (int i = 0; i < 12; i++) if (s[i]) p = i;
        sh = 11 - p;
        m  = s << sh;
        if (int'(e) < sh) begin
            eo = 8'd0;
            u  = 1'b1;
        end else begin
            eo = 8'(int'(e) - sh);
            u  = 1'b0;
        end
        return {m, 4'(sh), eo, (int'(c) != p), 1'b0, u, 1'b0};
    endfunction

    // Legal upstream beat: a+b of two 11-bit operands, prediction p or p+1
    task automatic gen_beat();
        logic [10:0] a;
        logic [10:0] b;
        int          p;
        a = 11'($urandom_range(0, 2047) >> $urandom_range(0, 11));
        b = 11'($urandom_range(0, 2047) >> $urandom_range(0, 11));
        sum    = 12'(a) + 12'(b);
        exp_in = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
        if (sum == 12'd0) begin
            v_pre = 1'b0;
            c_pre = 4'($urandom_range(0, 15));
        end else begin
            p = 0;
            for (int i = 0; i < 12; i++) if (sum[i]) p = i;
            v_pre = 1'b1;
            c_pre = 4'(p + ((p < 11) ? int'($urandom_range(0, 1)) : 0));
        end
    endtask

    // One cycle: sample between edges, score outputs, record accepted input, advance
    task automatic step();
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        if (out_valid) begin
            check("stream_has_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                check("stream", obs, q[0]);
                if (out_ready) void'(q.pop_front());
            end
        end
        if (in_valid && in_ready) q.push_back(model(sum, c_pre, v_pre, exp_in));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && (q.size() != 0 || out_valid); k++) step();
        check("drain_empty", q.size(), 0);
        check("drain_idle", out_valid, 0);
    endtask

    // Single directed beat into an empty pipe; returns with it presented at the output
    task automatic manual_beat(input logic [11:0] s, input logic [3:0] c, input logic v,
                               input logic [7:0] e);
        in_valid  = 1'b1;
        sum       = s;
        c_pre     = c;
        v_pre     = v;
        exp_in    = e;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
    endtask

    initial begin
        logic hold;
        logic exp_pe;

        vecs[0] = '{12'h060, 4'd6,  1'b1, 8'd20,  12'hC00, 4'd5,  8'd15,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{12'h060, 4'd7,  1'b1, 8'd20,  12'hC00, 4'd5,  8'd15,  1'b1, 1'b0, 1'b0};
        vecs[2] = '{12'h000, 4'd5,  1'b0, 8'd9,   12'h000, 4'd0,  8'd0,   1'b0, 1'b1, 1'b0};
        vecs[3] = '{12'h001, 4'd0,  1'b1, 8'd3,   12'h800, 4'd11, 8'd0,   1'b0, 1'b0, 1'b1};
        vecs[4] = '{12'h001, 4'd1,  1'b1, 8'd11,  12'h800, 4'd11, 8'd0,   1'b1, 1'b0, 1'b0};
        vecs[5] = '{12'hFFF, 4'd11, 1'b1, 8'd0,   12'hFFF, 4'd0,  8'd0,   1'b0, 1'b0, 1'b0};
        vecs[6] = '{12'hFFE, 4'd11, 1'b1, 8'd5,   12'hFFE, 4'd0,  8'd5,   1'b0, 1'b0, 1'b0};
        vecs[7] = '{12'h003, 4'd2,  1'b1, 8'd200, 12'hC00, 4'd10, 8'd190, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{12'h555, 4'd10, 1'b1, 8'd1,   12'hAAA, 4'd1,  8'd0,   1'b0, 1'b0, 1'b0};
        vecs[9] = '{12'h555, 4'd11, 1'b1, 8'd0,   12'hAAA, 4'd1,  8'd0,   1'b1, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sum       = '0;
        c_pre     = '0;
        v_pre     = 1'b0;
        exp_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, obs}, 0);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            manual_beat(vecs[i].sum, vecs[i].c_pre, vecs[i].v_pre, vecs[i].exp_in);
            check($sformatf("vec%0d", i), obs,
                  {vecs[i].mant, vecs[i].shamt, vecs[i].exp_out,
                   vecs[i].corr, vecs[i].zero, vecs[i].unf, 1'b0});
        end
        @(posedge clk);
        #1;
        check("vec_pipe_empty", out_valid, 0);

        // Back-to-back: 8 beats, outputs on 8 consecutive cycles after 2-cycle latency
        for (int k = 0; k < 10; k++) begin
            in_valid  = (k < 8);
            out_ready = 1'b1;
            if (k < 8) gen_beat();
            step();
            if (k < 8) check($sformatf("tput_in_ready%0d", k), s_in_ready, 1);
            check($sformatf("tput_out_valid%0d", k), s_out_valid, (k >= 2));
        end
        drain();

        // Backpressure: only two beats fit, payload must hold
        in_valid  = 1'b1;
        out_ready = 1'b0;
        gen_beat();
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("bp_in_ready%0d", k), s_in_ready, (k < 2));
            if (s_in_ready) gen_beat();
        end
        out_ready = 1'b1;
        #1;
        check("in_ready_comb_open", in_ready, 1);
        out_ready = 1'b0;
        #1;
        check("in_ready_comb_block", in_ready, 0);
        in_valid = 1'b0;
        drain();

        // Async reset with two beats in flight
        in_valid  = 1'b1;
        out_ready = 1'b1;
        gen_beat();
        step();
        gen_beat();
        step();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("rst_async_outputs", {out_valid, obs}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        in_valid = 1'b1;
        gen_beat();
        step();
        in_valid = 1'b0;
        check("post_rst_lat0", s_out_valid, 0);
        step();
        check("post_rst_lat1", s_out_valid, 0);
        step();
        check("post_rst_lat2", s_out_valid, 1);
        drain();

        // Random traffic with random backpressure; upstream holds a stalled beat
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 9) < 8);
                gen_beat();
            end
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            hold = in_valid && !s_in_ready;
        end
        drain();

        // Prediction-contract violation: true index 8, predicted 10
`ifdef NORM_PRED_CHECK_EN
        exp_pe = 1'b1;
`else
        exp_pe = 1'b0;
`endif
        manual_beat(12'h100, 4'd10, 1'b1, 8'd50);
        check("pred_err_set", pred_err, exp_pe);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        check("pred_err_sticky", pred_err, exp_pe);
        rst = 1'b1;
        #1;
        check("pred_err_reset", pred_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
